// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, fetches the 8-word block from memory,
// streams returned words into the data array and installs the tag on the last word.
// Build option CACHE_FILL_PERF_EN adds a saturating completed-fill counter (fill_count).
//
// state | meaning
// IDLE  | no fill; waiting for miss_detected, all strobes low
// FILL  | issuing the 8 word reads and writing returned words in order

module cache_fill_fsm #(
  parameter int SET_BITS = 7,
  parameter int TAG_BITS = 16 - SET_BITS - 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [15:0]              miss_address,
  input  logic                     memory_data_valid,
  input  logic [15:0]              memory_data,
  output logic                     fsm_busy,
  output logic                     mem_req,
  output logic [15:0]              memory_address,
  output logic                     write_data_array,
  output logic [(1<<SET_BITS)-1:0] block_enable,
  output logic [7:0]               word_enable,
  output logic [15:0]              data_out,
  output logic                     write_tag_array,
  output logic [TAG_BITS-1:0]      tag_out
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [15:0]              fill_count
`endif
);

  localparam int NUM_SETS = 1 << SET_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e              state_q;
  logic [11:0]         base_q;
  logic [2:0]          issue_cnt_q;
  logic [2:0]          recv_cnt_q;
  logic                issue_done_q;
  logic                recv_done_q;
  logic                fsm_busy_q;
  logic                mem_req_q;
  logic [15:0]         memory_address_q;
  logic [NUM_SETS-1:0] block_enable_q;

  logic                wr_strobe;
  logic                last_return;
  logic                issuing;
  logic [NUM_SETS-1:0] set_onehot;
  logic                unused_addr_bits;

  // The byte/word offset of the missing access does not matter: the whole block is fetched.
  assign unused_addr_bits = ^miss_address[3:0];

  assign set_onehot  = {{(NUM_SETS-1){1'b0}}, 1'b1} << miss_address[4 +: SET_BITS];
  assign issuing     = mem_req_q && !issue_done_q;
  assign wr_strobe   = (state_q == FILL) && memory_data_valid && !recv_done_q;
  assign last_return = wr_strobe && (recv_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      base_q           <= '0;
      issue_cnt_q      <= '0;
      recv_cnt_q       <= '0;
      issue_done_q     <= 1'b0;
      recv_done_q      <= 1'b0;
      fsm_busy_q       <= 1'b0;
      mem_req_q        <= 1'b0;
      memory_address_q <= '0;
      block_enable_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fsm_busy_q       <= 1'b0;
          mem_req_q        <= 1'b0;
          memory_address_q <= '0;
          block_enable_q   <= '0;
          if (miss_detected) begin
            state_q          <= FILL;
            base_q           <= miss_address[15:4];
            issue_cnt_q      <= '0;
            recv_cnt_q       <= '0;
            issue_done_q     <= 1'b0;
            recv_done_q      <= 1'b0;
            fsm_busy_q       <= 1'b1;
            mem_req_q        <= 1'b1;
            memory_address_q <= {miss_address[15:4], 4'b0000};
            block_enable_q   <= set_onehot;
          end
        end

        FILL: begin
          if (issuing) begin
            issue_cnt_q <= issue_cnt_q + 3'd1;
            if (issue_cnt_q == 3'd7) begin
              mem_req_q        <= 1'b0;
              issue_done_q     <= 1'b1;
              memory_address_q <= '0;
            end else begin
              memory_address_q <= {base_q, issue_cnt_q + 3'd1, 1'b0};
            end
          end
          if (wr_strobe) begin
            recv_cnt_q <= recv_cnt_q + 3'd1;
          end
          // Last word: leave FILL on this edge; the counter wraps to 0 together with the exit.
          if (last_return) begin
            state_q          <= IDLE;
            recv_done_q      <= 1'b1;
            fsm_busy_q       <= 1'b0;
            mem_req_q        <= 1'b0;
            memory_address_q <= '0;
            block_enable_q   <= '0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign fsm_busy         = fsm_busy_q;
  assign mem_req          = mem_req_q;
  assign memory_address   = memory_address_q;
  assign block_enable     = block_enable_q;
  assign write_data_array = wr_strobe;
  assign word_enable      = wr_strobe ? (8'd1 << recv_cnt_q) : 8'd0;
  assign data_out         = memory_data;
  assign write_tag_array  = last_return;
  assign tag_out          = base_q[11 -: TAG_BITS];

`ifdef CACHE_FILL_PERF_EN
  logic [15:0] fill_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_count_q <= '0;
    end else if (last_return && (fill_count_q != 16'hFFFF)) begin
      fill_count_q <= fill_count_q + 16'd1;
    end
  end

  assign fill_count = fill_count_q;
`endif

endmodule
